// File: rtl/bit_deposit_pkg.sv
// -----------------------------------------------------------------------------
// bit_deposit_pkg
//   Shared definitions for the bit deposit register: the write operation
//   encoding carried on the op port and the state encoding of the
//   auto-clear (row-complete flash) controller.
//
//   Contents:
//     op_e     - 2-bit write operation (OP_LOAD / OP_SET / OP_CLR / OP_TGL)
//     state_e  - controller state (ST_IDLE / ST_FLASH)
//     op_apply - result of applying one operation to a single stored bit
// -----------------------------------------------------------------------------
package bit_deposit_pkg;

    typedef enum logic [1:0] {
        OP_LOAD = 2'b00,  // bit <= bit_in
        OP_SET  = 2'b01,  // bit <= 1
        OP_CLR  = 2'b10,  // bit <= 0
        OP_TGL  = 2'b11   // bit <= ~bit
    } op_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,  // accepting writes
        ST_FLASH = 1'b1   // vector full, holding before the wipe
    } state_e;

    // New value of one stored bit under a given operation.
    function automatic logic op_apply(input op_e op, input logic cur, input logic bit_in);
        logic res;
        res = cur;
        unique case (op)
            OP_LOAD: res = bit_in;
            OP_SET:  res = 1'b1;
            OP_CLR:  res = 1'b0;
            OP_TGL:  res = ~cur;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/bit_deposit_decoder.sv
// -----------------------------------------------------------------------------
// bit_deposit_decoder
//   Purely combinational next-vector generator. Applies op to the bit of cur
//   addressed by sel and leaves every other bit untouched. A select at or
//   above NrOfDataBits addresses no stored bit: nxt equals cur and in_range
//   is low.
//
//   Ports:
//     sel       in   NrOfSelBits   target bit index
//     op        in   2             write operation (op_e encoding)
//     bit_in    in   1             value used by OP_LOAD
//     cur       in   NrOfDataBits  current stored vector
//     nxt       out  NrOfDataBits  vector after the write
//     in_range  out  1             sel addresses a stored bit
// -----------------------------------------------------------------------------
module bit_deposit_decoder
    import bit_deposit_pkg::*;
#(
    parameter int unsigned NrOfSelBits  = 3,
    parameter int unsigned NrOfDataBits = 8
) (
    input  logic [NrOfSelBits-1:0]  sel,
    input  logic [1:0]              op,
    input  logic                    bit_in,
    input  logic [NrOfDataBits-1:0] cur,
    output logic [NrOfDataBits-1:0] nxt,
    output logic                    in_range
);

    op_e op_dec;

    assign op_dec = op_e'(op);

    // Compare against each implemented index rather than a numeric bound so
    // the select never has to be widened to the parameter's width.
    always_comb begin
        nxt      = cur;
        in_range = 1'b0;
        for (int i = 0; i < int'(NrOfDataBits); i++) begin
            if (sel == i[NrOfSelBits-1:0]) begin
                in_range = 1'b1;
                nxt[i]   = op_apply(op_dec, cur[i], bit_in);
            end
        end
    end

endmodule

// File: rtl/bit_deposit_register.sv
// -----------------------------------------------------------------------------
// bit_deposit_register
//   Write-side counterpart of the bit selector. Holds an NrOfDataBits vector
//   and changes one bit per accepted write (load / set / clear / toggle),
//   addressed by sel. Reports all-ones / all-zeros, pulses once per rise of
//   full, and pulses on an accepted write whose select is out of range.
//
//   Build option BIT_DEPOSIT_AUTOCLEAR_EN:
//     defined   - once the vector becomes full, writes are refused for
//                 FlashCycles cycles, then the vector is wiped to zero.
//     undefined - no flash state; wr_ready is constant 1 and a full vector
//                 stays full until clear or further writes.
//
//   Ports:
//     clk               in   1             rising-edge clock
//     rst_n             in   1             asynchronous active-low reset
//     wr_valid          in   1             write request
//     wr_ready          out  1             write accepted when valid & ready
//     sel               in   NrOfSelBits   target bit index
//     op                in   2             00 load, 01 set, 10 clear, 11 toggle
//     bit_in            in   1             value for load
//     clear             in   1             synchronous wipe of the whole vector
//     data_out          out  NrOfDataBits  stored vector (registered)
//     full              out  1             data_out is all ones
//     empty             out  1             data_out is all zeros
//     full_pulse        out  1             one-cycle pulse on each rise of full
//     err_out_of_range  out  1             one-cycle pulse after an accepted
//                                          write with sel >= NrOfDataBits
// -----------------------------------------------------------------------------
module bit_deposit_register
    import bit_deposit_pkg::*;
#(
    parameter int unsigned NrOfSelBits  = 3,
    parameter int unsigned NrOfDataBits = 8,
    parameter int unsigned FlashCycles  = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    input  logic [NrOfSelBits-1:0]  sel,
    input  logic [1:0]              op,
    input  logic                    bit_in,
    input  logic                    clear,
    output logic [NrOfDataBits-1:0] data_out,
    output logic                    full,
    output logic                    empty,
    output logic                    full_pulse,
    output logic                    err_out_of_range
);

    logic [NrOfDataBits-1:0] data_q, data_d;
    logic [NrOfDataBits-1:0] write_data;  // vector after any write, before the flash wipe
    logic [NrOfDataBits-1:0] dec_data;
    logic                    dec_in_range;
    logic                    accept;
    logic                    full_pulse_q, full_pulse_d;
    logic                    err_q, err_d;

    bit_deposit_decoder #(
        .NrOfSelBits  (NrOfSelBits),
        .NrOfDataBits (NrOfDataBits)
    ) u_decoder (
        .sel      (sel),
        .op       (op),
        .bit_in   (bit_in),
        .cur      (data_q),
        .nxt      (dec_data),
        .in_range (dec_in_range)
    );

    assign accept = wr_valid & wr_ready;

    // Clear wins over a simultaneous write; an out-of-range write completes
    // its handshake but leaves the vector alone.
    always_comb begin
        write_data = data_q;
        if (clear) begin
            write_data = '0;
        end else if (accept && dec_in_range) begin
            write_data = dec_data;
        end
    end

`ifdef BIT_DEPOSIT_AUTOCLEAR_EN

    localparam int unsigned CntW    = (FlashCycles > 1) ? $clog2(FlashCycles) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(FlashCycles - 1);

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    assign wr_ready = (state_q == ST_IDLE);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = write_data;
        unique case (state_q)
            ST_IDLE: begin
                if ((&write_data) && !(&data_q)) begin
                    state_d = ST_FLASH;
                    cnt_d   = '0;
                end
            end
            ST_FLASH: begin
                // No writes are accepted here, so write_data is data_q or 0.
                if (clear || (cnt_q == CntLast)) begin
                    data_d  = '0;
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`else

    assign wr_ready = 1'b1;

    always_comb begin
        data_d = write_data;
    end

`endif

    // Pulse is registered alongside the data, so it is high exactly in the
    // first cycle that full is high.
    assign full_pulse_d = (&data_d) & ~(&data_q);
    assign err_d        = accept & ~clear & ~dec_in_range;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q       <= '0;
            full_pulse_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            data_q       <= data_d;
            full_pulse_q <= full_pulse_d;
            err_q        <= err_d;
        end
    end

    assign data_out         = data_q;
    assign full             = &data_q;
    assign empty            = ~|data_q;
    assign full_pulse       = full_pulse_q;
    assign err_out_of_range = err_q;

endmodule
